// File: rtl/imm_gen_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imm_gen_stage                                                            |
// | Registered RISC-V immediate generator with valid/ready on both sides.    |
// | Build option: IMM_SKID_EN selects the two-entry skid buffer.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  w_imm;
    logic             w_sign;
    logic             w_accept;
    logic             w_drain;
    logic             w_unused_opcode;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [TAG_W-1:0] r_main_tag;

    assign w_sign          = in_inst[31];
    assign w_unused_opcode = ^in_inst[6:0];

    always_comb begin
        w_imm = '0;
        case (in_imm_type)
            3'b000: w_imm = {{(XLEN-12){w_sign}}, in_inst[31:20]};
            3'b001: w_imm = '0;
            3'b010: w_imm = {{(XLEN-12){w_sign}}, in_inst[31:25], in_inst[11:7]};
            3'b011: w_imm = {{(XLEN-12){w_sign}}, in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            // Bit 31 of the U immediate is the sign, so XLEN=32 needs no special case.
            3'b100: w_imm = {{(XLEN-31){w_sign}}, in_inst[30:12], 12'h000};
            3'b101: w_imm = {{(XLEN-20){w_sign}}, in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
            3'b110: w_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
            3'b111: begin
                w_imm[4:0] = in_inst[24:20];
                if (XLEN == 64) begin
                    w_imm[5] = in_inst[25];
                end
            end
        endcase
    end

    assign w_drain   = r_main_valid && out_ready;
    assign w_accept  = in_valid && in_ready && !flush;
    assign out_valid = r_main_valid;
    assign out_imm   = r_main_imm;
    assign out_tag   = r_main_tag;

`ifdef IMM_SKID_EN
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;

    // Registered ready: the skid slot absorbs the one entry that may arrive
    // in the cycle downstream stalls.
    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_imm   <= r_skid_imm;
                r_main_tag   <= r_skid_tag;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_imm <= w_imm;
                    r_main_tag <= in_tag;
                end
            end
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_tag   <= in_tag;
        end
    end
`else
    assign in_ready = !r_main_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_tag   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (!r_main_valid || w_drain) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main_imm <= w_imm;
                r_main_tag <= in_tag;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imm_gen_stage                                                         |
// | Directed bench for imm_gen_stage at XLEN=32 and XLEN=64.                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_imm_gen_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_imm_type;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32,  out_valid32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64,  out_valid64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int n_vec = 0;
    int n_err = 0;

    imm_gen_stage #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] ty,
                         input logic [4:0] tag);
        in_valid    = v;
        in_inst     = inst;
        in_imm_type = ty;
        in_tag      = tag;
    endtask

    // I-format word whose immediate equals the (small, positive) tag.
    function automatic logic [31:0] tag_inst(input logic [4:0] t);
        return {7'd0, t, 20'h00093};
    endfunction

    localparam int NV = 11;
    logic [31:0] v_inst [NV] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7,
                                 32'h001000EF, 32'h0007D073, 32'h800002B7, 32'h03F09093,
                                 32'hFFFFFFFF, 32'h7FF00093, 32'h8000006F};
    logic [2:0]  v_type [NV] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd7,
                                 3'd1, 3'd0, 3'd5};
    logic [31:0] v_e32  [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                 32'h00000800, 32'h0000000F, 32'h80000000, 32'h0000001F,
                                 32'h00000000, 32'h000007FF, 32'hFFF00000};
    logic [63:0] v_e64  [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                 64'hFFFFFFFFFFFFFFF8, 64'h0000000012345000,
                                 64'h0000000000000800, 64'h000000000000000F,
                                 64'hFFFFFFFF80000000, 64'h000000000000003F,
                                 64'h0000000000000000, 64'h00000000000007FF,
                                 64'hFFFFFFFFFFF00000};

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #3;
        chk("rst_valid", out_valid32, 0);
        chk("rst_imm",   out_imm32,   0);
        chk("rst_tag",   out_tag32,   0);
        chk("rst_imm64", out_imm64,   0);
        step();
        rst = 1'b0;
        #2 chk("rst_ready", in_ready32, 1);
        step();

        // Format decode, isolated transfers so latency is visible.
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("fmt%0d_idle", i), out_valid32, 0);
            chk($sformatf("fmt%0d_rdy", i), in_ready32, 1);
            drive(1'b1, v_inst[i], v_type[i], 5'(i + 1));
            step();
            drive(1'b0, 32'h0, 3'd0, 5'd0);
            #2;
            chk($sformatf("fmt%0d_valid", i), out_valid32, 1);
            chk($sformatf("fmt%0d_imm32", i), out_imm32, v_e32[i]);
            chk($sformatf("fmt%0d_tag", i), out_tag32, 5'(i + 1));
            chk($sformatf("fmt%0d_imm64", i), out_imm64, v_e64[i]);
            step();
        end

        // Backpressure with tags 1,2,3.
        out_ready = 1'b0;
`ifdef IMM_SKID_EN
        drive(1'b1, tag_inst(5'd1), 3'd0, 5'd1);
        #2 chk("bp_rdy1", in_ready32, 1);
        step();
        drive(1'b1, tag_inst(5'd2), 3'd0, 5'd2);
        #2 chk("bp_rdy2", in_ready32, 1);
        chk("bp_tag1", out_tag32, 1);
        step();
        drive(1'b1, tag_inst(5'd3), 3'd0, 5'd3);
        #2 chk("bp_full", in_ready32, 0);
        step();
        #2;
        chk("bp_hold_valid", out_valid32, 1);
        chk("bp_hold_tag", out_tag32, 1);
        chk("bp_hold_rdy", in_ready32, 0);
        out_ready = 1'b1;
        #1 chk("bp_rel_tag", out_tag32, 1);
        step();
        #2;
        chk("bp_out2_tag", out_tag32, 2);
        chk("bp_out2_imm", out_imm32, 2);
        chk("bp_out2_rdy", in_ready32, 1);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2;
        chk("bp_out3_valid", out_valid32, 1);
        chk("bp_out3_tag", out_tag32, 3);
        step();
        #2 chk("bp_empty", out_valid32, 0);
`else
        drive(1'b1, tag_inst(5'd1), 3'd0, 5'd1);
        #2 chk("bp_rdy1", in_ready32, 1);
        step();
        drive(1'b1, tag_inst(5'd2), 3'd0, 5'd2);
        #2 chk("bp_full", in_ready32, 0);
        step();
        #2;
        chk("bp_hold_valid", out_valid32, 1);
        chk("bp_hold_tag", out_tag32, 1);
        out_ready = 1'b1;
        #1 chk("bp_rel_rdy", in_ready32, 1);
        step();
        #2;
        chk("bp_out2_tag", out_tag32, 2);
        chk("bp_out2_imm", out_imm32, 2);
        drive(1'b1, tag_inst(5'd3), 3'd0, 5'd3);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2;
        chk("bp_out3_valid", out_valid32, 1);
        chk("bp_out3_tag", out_tag32, 3);
        step();
        #2 chk("bp_empty", out_valid32, 0);
`endif
        step();

        // Flush with everything the stage can hold, plus a live input.
        out_ready = 1'b0;
        drive(1'b1, tag_inst(5'd4), 3'd0, 5'd4);
        step();
`ifdef IMM_SKID_EN
        drive(1'b1, tag_inst(5'd5), 3'd0, 5'd5);
        step();
        #2 chk("fl_two_rdy", in_ready32, 0);
`endif
        drive(1'b1, tag_inst(5'd6), 3'd0, 5'd6);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2;
        chk("fl_valid", out_valid32, 0);
        chk("fl_rdy", in_ready32, 1);
        step();
        #2 chk("fl_noacc", out_valid32, 0);
        drive(1'b1, tag_inst(5'd7), 3'd0, 5'd7);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2;
        chk("fl_next_valid", out_valid32, 1);
        chk("fl_next_tag", out_tag32, 7);
        step();

        // Flush with one entry held and in_ready high.
        out_ready = 1'b0;
        drive(1'b1, tag_inst(5'd8), 3'd0, 5'd8);
        step();
        drive(1'b1, tag_inst(5'd9), 3'd0, 5'd9);
        flush = 1'b1; out_ready = 1'b1;
        #2 chk("fl1_rdy", in_ready32, 1);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2 chk("fl1_valid", out_valid32, 0);
        step();
        #2 chk("fl1_noacc", out_valid32, 0);
        step();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'd0, 5'd11);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2 chk("ar_pre_valid", out_valid32, 1);
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid32, 0);
        chk("ar_imm", out_imm32, 0);
        chk("ar_tag", out_tag32, 0);
        #2 rst = 1'b0;
        #1 chk("ar_rdy", in_ready32, 1);
        out_ready = 1'b1;
        step();
        drive(1'b1, tag_inst(5'd12), 3'd0, 5'd12);
        #2 chk("ar_idle", out_valid32, 0);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        #2;
        chk("ar_new_valid", out_valid32, 1);
        chk("ar_new_tag", out_tag32, 12);
        chk("ar_new_imm", out_imm32, 12);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the RISC-V decode path. It takes a fetched instruction and an immediate-type selector from the decoder and produces the XLEN-wide extended immediate one cycle later. The stage sits between decode and register-read, uses valid/ready handshakes on both sides and passes a sideband tag through unchanged. Compared with the combinational 32-bit extender, it adds:

- XLEN generalisation;
- CSR-zimm and shift-amount formats;
- a flush input;
- optional full-throughput skid buffering.

## Interface
Parameters:
- XLEN, 32 — datapath width; legal values 32 or 64.
- TAG_W, 5 — width of the pass-through sideband tag (typically rd/ROB index).

Ports:
- clk  in  1  — clock; all state updates on the rising edge.
- rst  in  1  — asynchronous, active-high reset.
- flush  in  1  — synchronous; discards all held entries.
- in_valid  in  1  — upstream has an instruction.
- in_ready  out  1  — stage can accept this cycle.
- in_inst  in  32  — raw instruction word.
- in_imm_type  in  3  — immediate format selector.
- in_tag  in  TAG_W  — sideband, copied to out_tag.
- out_valid  out  1  — out_imm/out_tag are valid.
- out_ready  in  1  — downstream accepts this cycle.
- out_imm  out  XLEN  — extended immediate.
- out_tag  out  TAG_W  — tag of the entry on out_imm.

## Operation
Format decode. S = inst[31] replicated to fill XLEN.
- 000 I: S, inst[31:20]
- 001 none: 0
- 010 S-type: S, inst[31:25], inst[11:7]
- 011 B: S, inst[7], inst[30:25], inst[11:8], 1'b0
- 100 U: S (XLEN-32 bits), inst[31:12], 12'h0. On XLEN=64 this is sign-extended from bit 31.
- 101 J: S, inst[19:12], inst[20], inst[30:21], 1'b0
- 110 Z (CSR zimm): zero-extended inst[19:15]
- 111 shamt: zero-extended inst[25:20] when XLEN=64; inst[24:20] when XLEN=32.

Handshake and storage:
- A transfer occurs on in_valid && in_ready; the immediate is computed combinationally and registered with the tag.
- The output side transfers on out_valid && out_ready.
- Entries leave in acceptance order; no entry is duplicated or dropped except by flush/rst.
- out_imm/out_tag hold their value while out_valid && !out_ready.
- in_inst/in_imm_type are ignored when in_valid is low.

Flush:
- On the next edge, flush clears all valid bits; in_valid is ignored in a flush cycle (nothing accepted).
- in_ready during a flush cycle follows normal rules, but acceptance is suppressed.
- flush and rst have priority over any simultaneous transfer.

## Timing
- Reset values: out_valid=0, out_imm=0, out_tag=0, all internal valid bits 0. in_ready=1 immediately after rst deasserts (1 in both configurations).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- rst asserted mid-stream: all outputs go to reset values asynchronously; in-flight entries are lost.
- Buffer states with IMM_SKID_EN: EMPTY, ONE (main valid), TWO (main+skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept & drain → ONE; accept & !drain → TWO; drain & !accept → EMPTY.
  - TWO: drain → ONE, with skid moving to main. No accept in TWO.

## Configuration
- IMM_SKID_EN defined:
  - Two-entry skid buffer.
  - in_ready is a flop output (in_ready = !skid_valid) with no combinational path from out_ready.
  - Full throughput is sustained across a one-cycle stall.
- IMM_SKID_EN undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Only states EMPTY/ONE exist.
- All other behaviour is identical in both configurations.

## Test plan
- Formats at XLEN=32, out_ready=1:
  - I 0xFFF00093 → 0xFFFFFFFF
  - S 0xFE20AE23 → 0xFFFFFFFC
  - B 0xFE000CE3 → 0xFFFFFFF8
  - U 0x123452B7 → 0x12345000
  - J 0x001000EF → 0x00000800
  - Z 0x0007D073 → 0x0000000F
  - Each appears 1 cycle after acceptance.
- XLEN=64:
  - U 0x800002B7 → 0xFFFFFFFF80000000
  - shamt 0x03F09093 → 0x3F
  - type 001 → 0.
- Backpressure (IMM_SKID_EN), tags 1,2,3, out_ready=0:
  - Tags 1 and 2 accepted; in_ready falls the cycle after tag 2 is accepted; tag 3 is held.
  - out_ready=1 → tags 1,2,3 emerge in order on consecutive cycles.
- Without IMM_SKID_EN, same stimulus:
  - Only tag 1 is accepted while stalled.
  - With out_ready=1 after that, the stage streams one per cycle with no bubble.
- Flush with two entries held and in_valid=1:
  - The next cycle has out_valid=0, and the flush-cycle input is not accepted.
  - A following instruction emerges normally.
- rst pulse mid-stream:
  - out_valid drops to 0 without waiting for a clock edge, and out_imm/out_tag read 0.
  - After release, in_ready=1 and the first new instruction appears 1 cycle after acceptance.
